// File: rtl/skew_accum_ctrl_if.sv
// Stream and datapath bundle for skew_accum_ctrl: job start, offset input
// stream, result output stream and the link to the external adder datapath.
interface skew_accum_ctrl_if #(
   parameter int SIZE_INPUT  = 8,
   parameter int SIZE_OUTPUT = 16,
   parameter int SIZE_CODE   = 5,
   parameter int CNT_W       = 8
);
   logic                            start;
   logic [CNT_W-1:0]                cfg_len;
   logic                            in_valid;
   logic                            in_ready;
   logic [SIZE_INPUT*SIZE_CODE-1:0] in_offset;
   logic [SIZE_INPUT*SIZE_CODE-1:0] dp_offset;
   logic [SIZE_OUTPUT-1:0]          dp_numin;
   logic [SIZE_OUTPUT-1:0]          dp_out;
   logic                            out_valid;
   logic                            out_ready;
   logic [SIZE_OUTPUT-1:0]          out_data;
   logic                            busy;

   // Environment side: producer, consumer and datapath
   modport master (
      output start, cfg_len, in_valid, in_offset, dp_out, out_ready,
      input  in_ready, dp_offset, dp_numin, out_valid, out_data, busy
   );

   // Controller side
   modport slave (
      input  start, cfg_len, in_valid, in_offset, dp_out, out_ready,
      output in_ready, dp_offset, dp_numin, out_valid, out_data, busy
   );
endinterface

// File: rtl/skew_accum_ctrl.sv
// Multi-cycle accumulator controller around the skew_offset_add_signed
// datapath. Owns the running sum fed back into the adder's numin port,
// counts cfg_len beats per job and hands the finished sum downstream.
module skew_accum_ctrl #(
   parameter int SIZE_INPUT  = 8,
   parameter int SIZE_OUTPUT = 16,
   parameter int SIZE_CODE   = 5,
   parameter int CNT_W       = 8
) (
   input logic             clk,
   input logic             rst,
   skew_accum_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      OUTPUT
   } state_t;

   state_t                 state_q;
   logic [SIZE_OUTPUT-1:0] acc_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       len_q;
   logic [SIZE_OUTPUT-1:0] out_data_q;
   logic                   in_ready_q;
   logic                   out_valid_q;
   logic                   busy_q;
   logic                   beat;

   // A beat is an accepted offset word; in_ready is only high in ACCUM
   assign beat = bus.in_valid & in_ready_q;

   assign bus.dp_offset = bus.in_offset;
   assign bus.dp_numin  = acc_q;
   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.busy      = busy_q;

   // Job sequencer: state, running sum, term counter and registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         len_q       <= '0;
         out_data_q  <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  busy_q <= 1'b1;
                  if (bus.cfg_len != '0) begin
                     len_q      <= bus.cfg_len;
                     acc_q      <= '0;
                     cnt_q      <= '0;
                     in_ready_q <= 1'b1;
                     state_q    <= ACCUM;
                  end else begin
                     out_data_q  <= '0;
                     out_valid_q <= 1'b1;
                     state_q     <= OUTPUT;
                  end
               end
            end
            ACCUM: begin
               if (beat) begin
                  acc_q <= bus.dp_out;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == len_q - CNT_W'(1)) begin
                     out_data_q  <= bus.dp_out;
                     out_valid_q <= 1'b1;
                     in_ready_q  <= 1'b0;
                     state_q     <= OUTPUT;
                  end
               end
            end
            OUTPUT: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               in_ready_q  <= 1'b0;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_skew_accum_ctrl.sv
// Directed bench for skew_accum_ctrl with a behavioural stand-in for the
// skew_offset_add_signed datapath closing the numin/out loop.
module tb_skew_accum_ctrl;

   localparam int SIZE_INPUT  = 8;
   localparam int SIZE_OUTPUT = 16;
   localparam int SIZE_CODE   = 5;
   localparam int CNT_W       = 8;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   int   n;

   skew_accum_ctrl_if #(
      .SIZE_INPUT (SIZE_INPUT),
      .SIZE_OUTPUT(SIZE_OUTPUT),
      .SIZE_CODE  (SIZE_CODE),
      .CNT_W      (CNT_W)
   ) bus ();

   skew_accum_ctrl #(
      .SIZE_INPUT (SIZE_INPUT),
      .SIZE_OUTPUT(SIZE_OUTPUT),
      .SIZE_CODE  (SIZE_CODE),
      .CNT_W      (CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Free-running clock, 10 ns period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Datapath stand-in: lane i code shifted by i, top lane carries negative weight
   always_comb begin
      logic [SIZE_OUTPUT-1:0] sum;
      logic [SIZE_OUTPUT-1:0] term;
      sum = bus.dp_numin;
      for (int i = 0; i < SIZE_INPUT; i++) begin
         term = SIZE_OUTPUT'(bus.dp_offset[i*SIZE_CODE +: SIZE_CODE]) << i;
         if (i == SIZE_INPUT - 1) sum = sum - term;
         else                     sum = sum + term;
      end
      bus.dp_out = sum;
   end

   // Watchdog so a stuck run still ends with a report
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic st, input logic [CNT_W-1:0] len,
                                input logic iv, input logic [39:0] off,
                                input logic ordy);
      bus.start     = st;
      bus.cfg_len   = len;
      bus.in_valid  = iv;
      bus.in_offset = off;
      bus.out_ready = ordy;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      applyStimulus(1'b0, 8'd0, 1'b0, 40'h0, 1'b0);

      // Reset
      tick();
      tick();
      checkOutput("rst_out_valid", bus.out_valid, 0);
      checkOutput("rst_in_ready", bus.in_ready, 0);
      checkOutput("rst_busy", bus.busy, 0);
      checkOutput("rst_dp_numin", bus.dp_numin, 0);
      checkOutput("rst_out_data", bus.out_data, 0);
      rst = 1'b0;
      tick();

      // Basic job: three beats of +1, cfg_len changed after start must not matter
      applyStimulus(1'b1, 8'd3, 1'b0, 40'h0, 1'b1);
      tick();
      checkOutput("basic_in_ready", bus.in_ready, 1);
      checkOutput("basic_busy", bus.busy, 1);
      applyStimulus(1'b0, 8'd1, 1'b1, 40'h1, 1'b1);
      tick();
      checkOutput("basic_acc1", bus.dp_numin, 1);
      checkOutput("basic_no_early_done", bus.out_valid, 0);
      tick();
      tick();
      bus.in_valid = 1'b0;
      checkOutput("basic_out_valid", bus.out_valid, 1);
      checkOutput("basic_out_data", bus.out_data, 3);
      checkOutput("basic_in_ready_out", bus.in_ready, 0);
      tick();
      checkOutput("basic_idle_valid", bus.out_valid, 0);
      checkOutput("basic_idle_busy", bus.busy, 0);

      // Stall: gapped input and back-pressured output
      applyStimulus(1'b1, 8'd2, 1'b0, 40'h0, 1'b0);
      tick();
      applyStimulus(1'b0, 8'd2, 1'b1, 40'h1, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      checkOutput("stall_acc_held", bus.dp_numin, 1);
      checkOutput("stall_in_ready", bus.in_ready, 1);
      checkOutput("stall_not_done", bus.out_valid, 0);
      bus.in_valid = 1'b1;
      tick();
      for (int k = 0; k < 5; k++) begin
         checkOutput("stall_out_valid", bus.out_valid, 1);
         checkOutput("stall_out_data", bus.out_data, 2);
         checkOutput("stall_in_ready_out", bus.in_ready, 0);
         tick();
      end
      checkOutput("stall_acc_final", bus.dp_numin, 2);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      checkOutput("stall_released", bus.out_valid, 0);
      checkOutput("stall_idle_busy", bus.busy, 0);

      // Zero-length job
      applyStimulus(1'b1, 8'd0, 1'b0, 40'h0, 1'b0);
      tick();
      bus.start = 1'b0;
      checkOutput("zero_out_valid", bus.out_valid, 1);
      checkOutput("zero_out_data", bus.out_data, 0);
      checkOutput("zero_in_ready", bus.in_ready, 0);
      checkOutput("zero_busy", bus.busy, 1);
      bus.out_ready = 1'b1;
      tick();
      checkOutput("zero_done", bus.out_valid, 0);

      // Wrap: 255 beats of +0x0101 (lane 4 code 0x10 plus lane 0 code 1)
      applyStimulus(1'b1, 8'd255, 1'b0, 40'h0, 1'b0);
      tick();
      applyStimulus(1'b0, 8'd0, 1'b1, 40'h0001000001, 1'b0);
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 300) begin
         tick();
         n++;
      end
      bus.in_valid = 1'b0;
      checkOutput("wrap_beats", n, 255);
      checkOutput("wrap_out_data", bus.out_data, 32'hFFFF);
      bus.out_ready = 1'b1;
      tick();
      checkOutput("wrap_done", bus.out_valid, 0);

      // Reset mid-job, with start pulses in ACCUM ignored
      applyStimulus(1'b1, 8'd4, 1'b0, 40'h0, 1'b0);
      tick();
      applyStimulus(1'b0, 8'd4, 1'b1, 40'h1, 1'b0);
      tick();
      bus.start   = 1'b1;
      bus.cfg_len = 8'd1;
      tick();
      applyStimulus(1'b0, 8'd0, 1'b0, 40'h1, 1'b0);
      checkOutput("mid_acc2", bus.dp_numin, 2);
      checkOutput("mid_start_ignored", bus.out_valid, 0);
      checkOutput("mid_still_accum", bus.in_ready, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("mid_rst_busy", bus.busy, 0);
      checkOutput("mid_rst_numin", bus.dp_numin, 0);
      applyStimulus(1'b1, 8'd1, 1'b0, 40'h0, 1'b0);
      tick();
      applyStimulus(1'b0, 8'd0, 1'b1, 40'h1, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      checkOutput("mid_new_valid", bus.out_valid, 1);
      checkOutput("mid_new_data", bus.out_data, 1);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      checkOutput("mid_out_start_ignored", bus.out_data, 1);
      checkOutput("mid_out_hold", bus.out_valid, 1);
      bus.out_ready = 1'b1;
      tick();
      checkOutput("mid_final_idle", bus.busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
